// File: rtl/load_store_unit_if.sv
// Word-wide handshaked data bus between the load/store unit (master) and memory (slave).
// The master holds every request field stable until bus_ack or abort.
interface load_store_unit_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns single-cycle core memory accesses into handshaked word bus transfers,
// with byte-lane steering, load extension, misalignment detection and a bus timeout.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    MemRead,
   input  logic                    MemWrite,
   input  logic [2:0]              Funct3,
   input  logic [31:0]             Addr,
   input  logic [31:0]             WrData,
   output logic [31:0]             ReadData,
   output logic                    Stall,
   output logic                    AccErr,
   output logic                    BusErr,
   load_store_unit_if.master       bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_REQ   = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam logic [1:0] S_ABORT = 2'd3;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] rdata_q, rdata_d;

   logic        acc;
   logic        legal;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;

   // Select the addressed byte/half of the bus word and extend it to 32 bits.
   function automatic logic [31:0] load_ext(input logic [2:0]  f3,
                                            input logic [1:0]  off,
                                            input logic [31:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{off, 3'b000} +: 8];
      h = off[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  load_ext = {{24{b[7]}}, b};
         3'b001:  load_ext = {{16{h[15]}}, h};
         3'b100:  load_ext = {24'd0, b};
         3'b101:  load_ext = {16'd0, h};
         default: load_ext = w;
      endcase
   endfunction

   assign acc = MemRead | MemWrite;

   // Unsigned loads have no store counterpart; halves and words must be naturally aligned.
   always_comb begin
      legal = 1'b0;
      case (Funct3)
         3'b000:  legal = 1'b1;
         3'b001:  legal = ~Addr[0];
         3'b010:  legal = (Addr[1:0] == 2'b00);
         3'b100:  legal = ~MemWrite;
         3'b101:  legal = ~MemWrite & ~Addr[0];
         default: legal = 1'b0;
      endcase
   end

   always_comb begin
      lane_be    = 4'b1111;
      lane_wdata = WrData;
      case (Funct3[1:0])
         2'b00: begin
            lane_be    = 4'b0001 << Addr[1:0];
            lane_wdata = {4{WrData[7:0]}};
         end
         2'b01: begin
            lane_be    = 4'b0011 << Addr[1:0];
            lane_wdata = {2{WrData[15:0]}};
         end
         default: begin
            lane_be    = 4'b1111;
            lane_wdata = WrData;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      f3_d    = f3_q;
      off_d   = off_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (acc && legal) begin
               req_d   = 1'b1;
               we_d    = MemWrite;
               addr_d  = {Addr[31:2], 2'b00};
               wdata_d = lane_wdata;
               be_d    = lane_be;
               f3_d    = Funct3;
               off_d   = Addr[1:0];
               cnt_d   = 16'd0;
               state_d = S_REQ;
            end else if (acc) begin
               rdata_d = 32'd0;
            end
         end
         S_REQ: begin
            if (bus.bus_ack) begin
               req_d   = 1'b0;
               if (!we_q) rdata_d = load_ext(f3_q, off_q, bus.bus_rdata);
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               req_d   = 1'b0;
               rdata_d = 32'd0;
               state_d = S_ABORT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DONE: begin
            cnt_d   = 16'd0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = 16'd0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 16'd0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         rdata_q <= rdata_d;
      end
   end

   // Status outputs decode the state directly so reset silences them in the same cycle.
   always_comb begin
      Stall  = 1'b0;
      AccErr = 1'b0;
      BusErr = 1'b0;
      if (!reset) begin
         case (state_q)
            S_IDLE: begin
               Stall  = acc & legal;
               AccErr = acc & ~legal;
            end
            S_REQ:   Stall  = 1'b1;
            S_ABORT: BusErr = 1'b1;
            default: Stall  = 1'b0;
         endcase
      end
   end

   assign ReadData      = rdata_q;
   assign bus.bus_req   = req_q;
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_be    = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit: a driver issues accesses and queues the
// expected outcome, a responder models the memory, and a monitor checks what the DUT presents.
module tb_load_store_unit;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [2:0]  Funct3;
   logic [31:0] Addr, WrData;
   logic [31:0] ReadData;
   logic        Stall, AccErr, BusErr;

   load_store_unit_if bus_if ();

   load_store_unit #(.TIMEOUT(TO)) dut (
      .clk      (clk),
      .reset    (reset),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .Funct3   (Funct3),
      .Addr     (Addr),
      .WrData   (WrData),
      .ReadData (ReadData),
      .Stall    (Stall),
      .AccErr   (AccErr),
      .BusErr   (BusErr),
      .bus      (bus_if.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          legal;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rd;
      bit          buserr;
      int          stall_cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_rd = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int m_size(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit m_legal(input bit wr, input logic [2:0] f3, input logic [31:0] a);
      case (f3)
         3'd0:    return 1'b1;
         3'd1:    return (a % 2) == 0;
         3'd2:    return (a % 4) == 0;
         3'd4:    return !wr;
         3'd5:    return !wr && ((a % 2) == 0);
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] b;
      int n, off;
      n = m_size(f3);
      off = int'(a % 4);
      b = 4'd0;
      for (int i = 0; i < 4; i++)
         if (i >= off && i < off + n) b[i] = 1'b1;
      return b;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] w;
      int n;
      n = m_size(f3);
      w = 32'd0;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] m_ext(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] rdata);
      longint v;
      int n, off;
      n = m_size(f3);
      off = int'(a % 4);
      v = longint'(rdata >> (8 * off)) & ((64'sd1 <<< (8 * n)) - 1);
      if (!f3[2] && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
      return v[31:0];
   endfunction

   // ---------------- memory responder ----------------
   int          resp_delay = 0;
   logic [31:0] resp_rdata = 32'd0;
   bit          resp_manual = 1'b0;
   int          req_k = 0;

   always @(negedge clk) begin
      if (!resp_manual) begin
         if (bus_if.bus_req) begin
            req_k++;
            if (resp_delay != 0 && req_k == resp_delay) begin
               bus_if.bus_ack   = 1'b1;
               bus_if.bus_rdata = resp_rdata;
            end else begin
               bus_if.bus_ack   = 1'b0;
               bus_if.bus_rdata = $urandom;
            end
         end else begin
            req_k = 0;
            bus_if.bus_ack   = ($urandom_range(0, 3) == 0);
            bus_if.bus_rdata = $urandom;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   bit          mon_en = 1'b0;
   bit          rd_pending = 1'b0;
   logic [31:0] rd_pend_exp;
   int          stall_cnt = 0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rd_pending) begin
            check("ReadData", ReadData, rd_pend_exp);
            rd_pending = 1'b0;
         end
         if (bus_if.bus_req) begin
            if (exp_q.size() == 0) begin
               check("unexpected bus_req", 32'(bus_if.bus_req), 32'd0);
            end else begin
               check("bus_we", 32'(bus_if.bus_we), 32'(exp_q[0].we));
               check("bus_addr", bus_if.bus_addr, exp_q[0].addr);
               check("bus_be", 32'(bus_if.bus_be), 32'(exp_q[0].be));
               if (exp_q[0].we) check("bus_wdata", bus_if.bus_wdata, exp_q[0].wdata);
            end
         end
         if (Stall) begin
            stall_cnt++;
            check("AccErr while stalled", 32'(AccErr), 32'd0);
            check("BusErr while stalled", 32'(BusErr), 32'd0);
         end else if (MemRead || MemWrite) begin
            if (exp_q.size() == 0) begin
               check("unexpected commit", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("AccErr", 32'(AccErr), 32'(!e.legal));
               check("BusErr", 32'(BusErr), 32'(e.buserr));
               check("Stall cycles", 32'(stall_cnt), 32'(e.stall_cyc));
               if (!e.legal) check("bus_req on illegal", 32'(bus_if.bus_req), 32'd0);
               rd_pending  = 1'b1;
               rd_pend_exp = e.rd;
            end
            stall_cnt = 0;
         end else begin
            check("BusErr idle", 32'(BusErr), 32'd0);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_acc(input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int delay, input logic [31:0] rdat, input bit scramble);
      exp_t e;
      int n;
      e.legal  = m_legal(wr, f3, a);
      e.we     = wr;
      e.addr   = {a[31:2], 2'b00};
      e.be     = m_be(f3, a);
      e.wdata  = m_wdata(f3, wd);
      e.buserr = 1'b0;
      if (!e.legal) begin
         e.rd = 32'd0;
         e.stall_cyc = 0;
      end else if (delay == 0 || delay > TO) begin
         e.rd = 32'd0;
         e.buserr = 1'b1;
         e.stall_cyc = 1 + TO;
      end else begin
         e.rd = wr ? last_rd : m_ext(f3, a, rdat);
         e.stall_cyc = 1 + delay;
      end
      last_rd = e.rd;
      exp_q.push_back(e);
      resp_delay = delay;
      resp_rdata = rdat;
      @(posedge clk);
      #1;
      MemRead = rd; MemWrite = wr; Funct3 = f3; Addr = a; WrData = wd;
      n = 0;
      forever begin
         @(negedge clk);
         if (!Stall) break;
         if (scramble && n >= 1) begin
            Addr = $urandom; WrData = $urandom; Funct3 = 3'($urandom_range(0, 7));
         end
         n++;
         if (n > 64) begin
            errors++;
            $display("FAIL commit timeout: Stall still %0d after %0d cycles", Stall, n);
            break;
         end
      end
   endtask

   task automatic idle_cycles(input int k);
      for (int i = 0; i < k; i++) begin
         @(posedge clk);
         #1;
         MemRead = 1'b0; MemWrite = 1'b0;
      end
   endtask

   initial begin
      reset = 1'b1;
      MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b011; Addr = 32'h0; WrData = 32'h0;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset AccErr", 32'(AccErr), 32'd0);
      check("reset Stall", 32'(Stall), 32'd0);
      check("reset ReadData", ReadData, 32'd0);
      check("reset bus_req", 32'(bus_if.bus_req), 32'd0);
      check("reset BusErr", 32'(BusErr), 32'd0);
      Funct3 = 3'b010;
      #1;
      check("reset Stall legal", 32'(Stall), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0; MemRead = 1'b0;
      mon_en = 1'b1;

      do_acc(1, 0, 3'b000, 32'h103, 32'h0, 3, 32'h8000_0000, 0);        // LB
      do_acc(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 1, 32'h0, 0);       // SH
      do_acc(1, 0, 3'b010, 32'h101, 32'h0, 1, 32'h0, 0);               // misaligned LW
      do_acc(1, 0, 3'b010, 32'h040, 32'h0, 0, 32'h0, 0);               // timeout
      do_acc(1, 0, 3'b101, 32'h002, 32'h0, 1, 32'hBEEF_0000, 0);       // LHU
      do_acc(0, 1, 3'b100, 32'h010, 32'h55, 1, 32'h0, 0);              // SBU illegal
      do_acc(1, 0, 3'b010, 32'h080, 32'h0, TO, 32'hCAFE_F00D, 1);      // ack on last REQ cycle
      idle_cycles(1);

      for (int t = 0; t < 300; t++) begin
         bit rd, wr;
         int sel;
         sel = $urandom_range(0, 3);
         rd = (sel != 1);
         wr = (sel == 1) || (sel == 3);
         do_acc(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, TO + 1), $urandom, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      end
      idle_cycles(2);

      // reset in the middle of a request, followed by a stray ack
      mon_en = 1'b0;
      rd_pending = 1'b0;
      exp_q.delete();
      resp_manual = 1'b1;
      bus_if.bus_ack = 1'b0;
      @(posedge clk);
      #1;
      MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h44;
      @(posedge clk);
      #1;
      check("mid bus_req", 32'(bus_if.bus_req), 32'd1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("reset forces Stall", 32'(Stall), 32'd0);
      @(posedge clk);
      #1;
      check("reset drops bus_req", 32'(bus_if.bus_req), 32'd0);
      reset = 1'b0; MemRead = 1'b0;
      bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      check("late ack bus_req", 32'(bus_if.bus_req), 32'd0);
      check("late ack Stall", 32'(Stall), 32'd0);
      check("late ack ReadData", ReadData, 32'd0);
      check("late ack BusErr", 32'(BusErr), 32'd0);
      bus_if.bus_ack = 1'b0;
      resp_manual = 1'b0;
      last_rd = 32'd0;
      stall_cnt = 0;
      mon_en = 1'b1;
      do_acc(1, 0, 3'b000, 32'h07, 32'h0, 2, 32'h7F00_0000, 0);        // IDLE after reset
      idle_cycles(2);
      @(negedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
